// File: rtl/i2s_rx.sv
`timescale 1ns/1ps
// I2S receiver: synchronises and deglitches the user-port pins, deserialises
// MSB-first words and emits left/right pairs with a one-cycle valid strobe.
module i2s_rx #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bclk_in,
   input  logic             ws_in,
   input  logic             data_in,
   output logic [WIDTH-1:0] left,
   output logic [WIDTH-1:0] right,
   output logic             sample_valid,
   output logic             active
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam int unsigned TW = $clog2(TIMEOUT) + 1;

   typedef enum logic {SYNC, RUN} state_t;

   logic [1:0]       r_bclk_s, r_ws_s, r_data_s;
   logic [1:0]       r_ws_p, r_data_p;
   logic             r_bclk_d, r_bclk_f, r_bclk_fq;
   logic             w_edge, w_ws, w_data;

   state_t           r_state;
   logic             r_seen, r_prev_ws, r_pend_v;
   logic [WIDTH-1:0] r_shift, r_pend, w_word;
   logic [CW-1:0]    r_bitcnt;
   logic [TW-1:0]    r_tcnt;

   // ws/data get two extra stages so they line up with the filtered bclk edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bclk_s  <= '0;
         r_ws_s    <= '0;
         r_data_s  <= '0;
         r_ws_p    <= '0;
         r_data_p  <= '0;
         r_bclk_d  <= 1'b0;
         r_bclk_f  <= 1'b0;
         r_bclk_fq <= 1'b0;
      end else begin
         r_bclk_s  <= {r_bclk_s[0], bclk_in};
         r_ws_s    <= {r_ws_s[0], ws_in};
         r_data_s  <= {r_data_s[0], data_in};
         r_ws_p    <= {r_ws_p[0], r_ws_s[1]};
         r_data_p  <= {r_data_p[0], r_data_s[1]};
         r_bclk_d  <= r_bclk_s[1];
         if (r_bclk_s[1] == r_bclk_d)
            r_bclk_f <= r_bclk_s[1];
         r_bclk_fq <= r_bclk_f;
      end
   end

   assign w_edge = r_bclk_f & ~r_bclk_fq;
   assign w_ws   = r_ws_p[1];
   assign w_data = r_data_p[1];

   // Unwritten shift bits are always zero, so bits past WIDTH are simply dropped
   always_comb begin
      w_word = r_shift;
      for (int unsigned i = 0; i < WIDTH; i++)
         if (r_bitcnt == CW'(WIDTH - 1 - i))
            w_word[i] = w_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= SYNC;
         r_seen       <= 1'b0;
         r_prev_ws    <= 1'b0;
         r_shift      <= '0;
         r_bitcnt     <= '0;
         r_pend       <= '0;
         r_pend_v     <= 1'b0;
         r_tcnt       <= '0;
         left         <= '0;
         right        <= '0;
         sample_valid <= 1'b0;
         active       <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         if (w_edge) begin
            r_tcnt    <= '0;
            r_prev_ws <= w_ws;
            case (r_state)
               SYNC: begin
                  r_seen <= 1'b1;
                  if (r_seen && (w_ws != r_prev_ws)) begin
                     r_shift  <= '0;
                     r_bitcnt <= '0;
                     r_state  <= RUN;
                  end
               end
               RUN: begin
                  if (w_ws == r_prev_ws) begin
                     r_shift <= w_word;
                     if (r_bitcnt < CW'(WIDTH))
                        r_bitcnt <= r_bitcnt + 1'b1;
                  end else begin
                     r_shift  <= '0;
                     r_bitcnt <= '0;
                     if (!r_prev_ws) begin
                        r_pend   <= w_word;
                        r_pend_v <= 1'b1;
                     end else if (r_pend_v) begin
                        left         <= r_pend;
                        right        <= w_word;
                        sample_valid <= 1'b1;
                        active       <= 1'b1;
                        r_pend_v     <= 1'b0;
                     end
                  end
               end
               default: r_state <= SYNC;
            endcase
         end else if (r_tcnt != TW'(TIMEOUT)) begin
            r_tcnt <= r_tcnt + 1'b1;
            // Lost stream: silence the outputs once and wait for a fresh sync
            if (r_tcnt == TW'(TIMEOUT - 1)) begin
               r_state  <= SYNC;
               r_seen   <= 1'b0;
               r_pend   <= '0;
               r_pend_v <= 1'b0;
               left     <= '0;
               right    <= '0;
               active   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2s_rx.sv
`timescale 1ns/1ps
// Scoreboard bench for i2s_rx: a serial transmitter task queues expected pairs,
// a forked monitor pops and compares them on each sample_valid pulse.
module tb_i2s_rx;

   localparam int W  = 16;
   localparam int TO = 64;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         bclk_in = 1'b0, ws_in = 1'b0, data_in = 1'b0;
   logic [W-1:0] left, right;
   logic         sample_valid, active;

   i2s_rx #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .bclk_in      (bclk_in),
      .ws_in        (ws_in),
      .data_in      (data_in),
      .left         (left),
      .right        (right),
      .sample_valid (sample_valid),
      .active       (active)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] l;
      logic [W-1:0] r;
      int unsigned  c;
   } exp_t;

   exp_t        sb[$];
   exp_t        m_e;
   int          n_cmp = 0, n_err = 0, n_pulse = 0;
   int          cnt0;
   int unsigned lat;
   logic [31:0] tx_words[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] align(input logic [31:0] w, input int nb);
      if (nb >= W) return W'(w >> (nb - W));
      else         return W'(w << (W - nb));
   endfunction

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (!reset && sample_valid) begin
            n_pulse++;
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_pulse: got left=%h right=%h, required no pulse", left, right);
            end else begin
               m_e = sb.pop_front();
               chk("pair_left", 32'(left), 32'(m_e.l));
               chk("pair_right", 32'(right), 32'(m_e.r));
               lat = cyc - m_e.c;
               n_cmp++;
               if (lat < 2 || lat > 5) begin
                  n_err++;
                  $display("FAIL latency: got %0d clk after bclk rise, required 2..5", lat);
               end
            end
         end
      end
   endtask

   // Word 0/1 act as the sync frame; pairs from word 2 on are expected out.
   // I2S data lags ws by one bit, so the final right LSB needs one trailing edge.
   task automatic tx(input int nb, input int nw, input bit glitch);
      int total = nb * nw;
      @(negedge clk);
      for (int p = 0; p <= total; p++) begin
         logic [31:0] w;
         bclk_in = 1'b0;
         ws_in   = ((p / nb) % 2) == 1;
         if (p == 0) data_in = 1'b0;
         else begin
            w       = tx_words[(p - 1) / nb];
            data_in = w[nb - 1 - ((p - 1) % nb)];
         end
         if (glitch) begin
            @(negedge clk); bclk_in = 1'b1;
            @(negedge clk); bclk_in = 1'b0;
            @(negedge clk);
            @(negedge clk);
         end else
            repeat (4) @(negedge clk);
         bclk_in = 1'b1;
         if (p > 0 && (p % nb) == 0 && ((p / nb - 1) % 2) == 1 && (p / nb - 1) >= 3)
            sb.push_back('{align(tx_words[p / nb - 2], nb), align(tx_words[p / nb - 1], nb), cyc});
         repeat (4) @(negedge clk);
      end
      bclk_in = 1'b0;
   endtask

   initial begin
      fork
         monitor();
      join_none

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         bclk_in = 1'($urandom_range(0, 1));
         ws_in   = 1'($urandom_range(0, 1));
         data_in = 1'($urandom_range(0, 1));
         chk("reset_hold_lr", {left, right}, 32'h0);
         chk("reset_hold_flags", {30'h0, sample_valid, active}, 32'h0);
      end
      @(negedge clk);
      bclk_in = 1'b0; ws_in = 1'b0; data_in = 1'b0; reset = 1'b0;
      repeat (10) @(negedge clk);

      tx_words[0] = 32'h1111; tx_words[1] = 32'h2222;
      tx_words[2] = 32'h1234; tx_words[3] = 32'hABCD;
      cnt0 = n_pulse;
      tx(16, 4, 1'b0);
      repeat (8) @(negedge clk);
      chk("basic_pulses", n_pulse - cnt0, 1);
      chk("basic_active", {31'h0, active}, 1);
      chk("basic_left_held", 32'(left), 32'h1234);
      chk("basic_sb_drained", sb.size(), 0);

      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_lr", {left, right}, 32'h0);
      chk("async_reset_active", {31'h0, active}, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      tx_words[0] = 32'h11111111; tx_words[1] = 32'h22222222;
      tx_words[2] = 32'h7FEDCB00; tx_words[3] = 32'h80012300;
      tx(32, 4, 1'b0);
      repeat (8) @(negedge clk);
      chk("wide_active", {31'h0, active}, 1);
      chk("wide_sb_drained", sb.size(), 0);
      repeat (TO + 20) @(negedge clk);

      tx_words[0] = 32'h11; tx_words[1] = 32'h22;
      tx_words[2] = 32'hA5; tx_words[3] = 32'h3C;
      tx(8, 4, 1'b0);
      repeat (8) @(negedge clk);
      chk("short_right_held", 32'(right), 32'h3C00);
      chk("short_sb_drained", sb.size(), 0);
      repeat (TO + 20) @(negedge clk);

      tx_words[0] = 32'h1111; tx_words[1] = 32'h2222;
      tx_words[2] = 32'h5555; tx_words[3] = 32'hAAAA;
      tx_words[4] = 32'h5555; tx_words[5] = 32'hAAAA;
      cnt0 = n_pulse;
      tx(16, 6, 1'b1);
      repeat (8) @(negedge clk);
      chk("glitch_pulses", n_pulse - cnt0, 2);
      chk("glitch_lr_held", {left, right}, 32'h5555AAAA);

      repeat (32) @(negedge clk);
      chk("pre_timeout_active", {31'h0, active}, 1);
      repeat (40) @(negedge clk);
      chk("timeout_active", {31'h0, active}, 0);
      chk("timeout_lr_silent", {left, right}, 32'h0);

      tx_words[0] = 32'h1357; tx_words[1] = 32'h2468;
      tx_words[2] = 32'h0F0F; tx_words[3] = 32'hF0F0;
      cnt0 = n_pulse;
      tx(16, 4, 1'b0);
      repeat (8) @(negedge clk);
      chk("restart_pulses", n_pulse - cnt0, 1);
      chk("restart_active", {31'h0, active}, 1);

      repeat (20) @(negedge clk);
      chk("sb_drained_end", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Standalone I2S receiver for the MT32-pi audio path on the user port.
- Takes the already-routed bit clock, word-select and data pins (straight/crossed selection is done upstream).
- Synchronises, deglitches and deserialises them into left/right PCM sample pairs with a one-cycle valid strobe, and reports whether a live I2S stream is present.
- Sits directly downstream of the pin-selection logic and directly upstream of the AUDIO_L/AUDIO_R output registers, which load only on sample_valid.

Parameters:
- WIDTH, 16: output sample width in bits; received words are MSB-aligned into this width.
- TIMEOUT, 4096: clk cycles without a rising bclk edge before the stream is declared lost.

Ports:
- clk  input  1  audio clock (CLK_AUDIO, 24.576 MHz); all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- bclk_in  input  1  raw I2S bit clock from user port, asynchronous to clk.
- ws_in  input  1  raw I2S word select; 0 = left, 1 = right.
- data_in  input  1  raw I2S serial data, MSB first.
- left  output  WIDTH  last complete left sample, two's complement.
- right  output  WIDTH  last complete right sample, two's complement.
- sample_valid  output  1  one-cycle pulse when left/right update as a pair.
- active  output  1  high while a valid stream is being received.

Behaviour:
- Reset (async assert, sync release): left=0, right=0, sample_valid=0, active=0, state=SYNC. Shift register, bit counter and pending-left register are cleared.
- Input conditioning: each of bclk_in/ws_in/data_in passes a 2-flop synchroniser. bclk additionally passes a deglitcher: the filtered bclk takes the synchronised value only when two consecutive synchronised samples agree. A pulse of 1 clk is therefore ignored.
- A rising edge of filtered bclk produces an edge event in the clk cycle it is seen. ws and data are sampled together with that event, from their synchroniser outputs, delayed to match the bclk filter.
- States:
  - SYNC: on each edge event record ws. On the first edge where ws differs from the previous edge's ws, clear the shift register and bit counter, then go to RUN. The bit sampled on that edge is discarded.
  - RUN, edge with ws unchanged: if bitcnt < WIDTH, write data to shift bit (WIDTH-1-bitcnt) and increment bitcnt. Otherwise ignore the bit (bitcnt saturates at WIDTH). Longer slots therefore keep their top WIDTH bits; shorter words are zero-padded in the LSBs.
  - RUN, edge with ws changed (I2S: ws changes one bclk before the MSB): the bit on this edge is the LSB of the finishing word and is stored under the same rule first. The word is then complete; its channel is the previous ws. Shift register and bitcnt clear for the next word.
- Word commit:
  - Left word: stored in pending_left; nothing is output.
  - Right word with a pending left captured since the last pair: left<=pending_left, right<=word, and sample_valid pulses high in the next clk cycle, for 1 cycle. active<=1 in the same cycle.
  - Right word without a pending left (first word after SYNC): discarded, no pulse.
- Latency: the edge event for the final right LSB is followed by sample_valid and the updated outputs exactly 1 clk later. From the raw bclk_in rise this is at most 5 clk.
- Timeout: a counter increments every clk and clears on each edge event. On reaching TIMEOUT: state=SYNC, active=0, left=right=0 (a lost stream produces silence, not held DC), pending cleared, no sample_valid. The counter saturates; there is no repeated action.
- Simultaneous events: reset dominates everything. A timeout cannot coincide with an edge event, because the edge clears the counter first.
- Reset mid-word: the partial word is lost and the next pair requires a fresh SYNC. Outputs stay 0 until the first full pair.
- Arithmetic: bitcnt is clog2(WIDTH)+1 bits; the timeout counter is clog2(TIMEOUT)+1 bits. No sign extension is performed.

Test Plan:
- Reset: hold reset, toggle all inputs → left=0, right=0, sample_valid=0, active=0 throughout; async assert mid-cycle clears outputs immediately.
- Basic frame: bclk = clk/8, 16-bit slots, one sync frame, then L=0x1234 R=0xABCD → exactly one sample_valid pulse 1 clk after the right LSB edge, left=0x1234, right=0xABCD, active=1; the first partial frame produces no pulse.
- Wide slot: 32-bit slots carrying 24-bit data L=0x7FEDCB00 R=0x80012300, WIDTH=16 → left=0x7FED, right=0x8001.
- Short slot: 8-bit slots L=0xA5 R=0x3C → left=0xA500, right=0x3C00.
- Glitch rejection: inject 1-clk high pulses on bclk_in in the bclk-low phase during a 0x5555/0xAAAA stream → outputs exactly 0x5555/0xAAAA, pulse count unchanged.
- Timeout: stop bclk after a valid pair, TIMEOUT=64 → active drops and left=right=0 after 64 clk without an edge. On restart, the first pulse appears only after a SYNC plus one full L/R pair.
